// File: rtl/dmem_responder.sv
// Data-memory responder: services one load/store per transaction with LATENCY-cycle access, Valid/Fault pulse in DONE.
// Stall holds the MEM stage from the request cycle until DONE; throughput is one access per LATENCY+1 cycles.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData,
    output logic        Stall,
    output logic        Valid,
    output logic        Fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+2:0]   addr_q;
    logic [63:0]     wdata_q;
    logic            rd_q, wr_q;
    logic [63:0]     rdata_q;
    logic [63:0]     mem_q [DEPTH];

    logic            req;
    logic            commit;
    logic            from_in;
    logic            c_rd, c_wr, c_mis;
    logic [AW+2:0]   c_addr;
    logic [63:0]     c_wdata;
    logic [AW-1:0]   c_idx;
    logic            unused_addr_bits;

    assign req              = MemRead || MemWrite;
    assign unused_addr_bits = ^Address[63:AW+3];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Stall    = reset_n && ((state_q == IDLE && req) || state_q == BUSY);
        Valid    = (state_q == DONE);
        Fault    = (state_q == DONE) && (addr_q[2:0] != 3'b000);
        ReadData = rdata_q;
    end

    // With LATENCY=1 the commit edge is the request edge, so operands come straight from the inputs.
    assign from_in = (state_q == IDLE);
    assign commit  = reset_n && ((state_q == IDLE && req && LATENCY == 1) ||
                                 (state_q == BUSY && cnt_q == CW'(1)));
    assign c_rd    = from_in ? MemRead      : rd_q;
    assign c_wr    = from_in ? MemWrite     : wr_q;
    assign c_addr  = from_in ? Address[AW+2:0] : addr_q;
    assign c_wdata = from_in ? WriteData    : wdata_q;
    assign c_idx   = c_addr[AW+2:3];
    assign c_mis   = (c_addr[2:0] != 3'b000);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                addr_q  <= Address[AW+2:0];
                wdata_q <= WriteData;
                rd_q    <= MemRead;
                wr_q    <= MemWrite;
            end
            if (commit) begin
                if (c_mis)             rdata_q <= '0;
                else if (c_rd && c_wr) rdata_q <= c_wdata;
                else if (c_rd)         rdata_q <= mem_q[c_idx];
            end
        end
    end

    // Storage is deliberately left unreset; commit already excludes reset cycles.
    always_ff @(posedge clock) begin
        if (commit && c_wr && !c_mis) mem_q[c_idx] <= c_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) driven from a vector table plus a reset-abort sequence.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rn   [3];
    logic        mr   [3];
    logic        mw   [3];
    logic [63:0] addr [3];
    logic [63:0] wd   [3];
    logic [63:0] rdd  [3];
    logic        stl  [3];
    logic        vld  [3];
    logic        flt  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.DEPTH(256), .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))) u_dut (
            .clock(clk), .reset_n(rn[g]), .MemRead(mr[g]), .MemWrite(mw[g]),
            .Address(addr[g]), .WriteData(wd[g]), .ReadData(rdd[g]),
            .Stall(stl[g]), .Valid(vld[g]), .Fault(flt[g])
        );
    end

    typedef struct {
        int          d;
        bit          r;
        bit          w;
        logic [63:0] a;
        logic [63:0] wdat;
        logic [63:0] erd;
        bit          eflt;
    } vec_t;

    typedef struct {
        logic [63:0] rd;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic access(input int d, input bit r, input bit w, input logic [63:0] a,
                          input logic [63:0] wdat, input logic [63:0] erd, input bit eflt);
        int   n;
        int   st;
        exp_t e;
        sb.push_back('{rd: erd, flt: eflt});
        @(negedge clk);
        mr[d] = r; mw[d] = w; addr[d] = a; wd[d] = wdat;
        #1;
        n = 0; st = 0;
        while (!vld[d] && n < 40) begin
            if (stl[d]) st++;
            @(negedge clk); #1;
            n++;
        end
        if (!vld[d]) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: inst %0d addr %h no Valid after %0d cycles", d, a, n);
        end
        e = sb.pop_front();
        cmp($sformatf("latency[%0d]@%h", d, a), 64'(n), 64'(lat(d)));
        cmp($sformatf("stall_cycles[%0d]@%h", d, a), 64'(st), 64'(lat(d)));
        cmp($sformatf("stall_in_done[%0d]@%h", d, a), 64'(stl[d]), 64'(0));
        cmp($sformatf("rdata[%0d]@%h", d, a), rdd[d], e.rd);
        cmp($sformatf("fault[%0d]@%h", d, a), 64'(flt[d]), 64'(e.flt));
        mr[d] = 1'b0; mw[d] = 1'b0;
        @(negedge clk); #1;
        cmp($sformatf("valid_pulse[%0d]@%h", d, a), 64'(vld[d]), 64'(0));
        cmp($sformatf("fault_pulse[%0d]@%h", d, a), 64'(flt[d]), 64'(0));
    endtask

    initial begin
        vec_t vt[15];
        int   nv;
        vt[0]  = '{0, 1'b0, 1'b1, 64'h10,  64'hDEADBEEF_01234567, 64'h0,                  1'b0};
        vt[1]  = '{0, 1'b1, 1'b0, 64'h10,  64'h0,                64'hDEADBEEF_01234567, 1'b0};
        vt[2]  = '{0, 1'b0, 1'b1, 64'h13,  64'hFF,               64'h0,                  1'b1};
        vt[3]  = '{0, 1'b1, 1'b0, 64'h10,  64'h0,                64'hDEADBEEF_01234567, 1'b0};
        vt[4]  = '{0, 1'b0, 1'b1, 64'h800, 64'hAA,               64'hDEADBEEF_01234567, 1'b0};
        vt[5]  = '{0, 1'b1, 1'b0, 64'h0,   64'h0,                64'hAA,                 1'b0};
        vt[6]  = '{0, 1'b1, 1'b1, 64'h20,  64'h77,               64'h77,                 1'b0};
        vt[7]  = '{0, 1'b1, 1'b0, 64'h20,  64'h0,                64'h77,                 1'b0};
        vt[8]  = '{0, 1'b1, 1'b0, 64'h13,  64'h0,                64'h0,                  1'b1};
        vt[9]  = '{0, 1'b0, 1'b1, 64'h7F8, 64'h1234,             64'h0,                  1'b0};
        vt[10] = '{0, 1'b1, 1'b0, 64'h7F8, 64'h0,                64'h1234,               1'b0};
        vt[11] = '{1, 1'b0, 1'b1, 64'h8,   64'h5,                64'h0,                  1'b0};
        vt[12] = '{1, 1'b1, 1'b0, 64'h8,   64'h0,                64'h5,                  1'b0};
        vt[13] = '{2, 1'b0, 1'b1, 64'h18,  64'h55,               64'h0,                  1'b0};
        vt[14] = '{2, 1'b1, 1'b0, 64'h18,  64'h0,                64'h55,                 1'b0};
        nv = 15;

        for (int i = 0; i < 3; i++) begin
            rn[i] = 1'b0; mr[i] = 1'b0; mw[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        mr[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("reset_rdata[%0d]", i), rdd[i], 64'h0);
            cmp($sformatf("reset_valid[%0d]", i), 64'(vld[i]), 64'(0));
            cmp($sformatf("reset_stall[%0d]", i), 64'(stl[i]), 64'(0));
            cmp($sformatf("reset_fault[%0d]", i), 64'(flt[i]), 64'(0));
        end
        mr[0] = 1'b0;
        for (int i = 0; i < 3; i++) rn[i] = 1'b1;

        for (int i = 0; i < nv; i++)
            access(vt[i].d, vt[i].r, vt[i].w, vt[i].a, vt[i].wdat, vt[i].erd, vt[i].eflt);

        // Reset in the 2nd Stall cycle of a LATENCY=4 store must discard it.
        begin
            int vcount;
            @(negedge clk);
            mw[2] = 1'b1; addr[2] = 64'h18; wd[2] = 64'h99;
            #1;
            cmp("abort_stall_t0", 64'(stl[2]), 64'(1));
            @(negedge clk); #1;
            cmp("abort_stall_t1", 64'(stl[2]), 64'(1));
            rn[2] = 1'b0; mw[2] = 1'b0;
            #1;
            cmp("abort_stall_drop", 64'(stl[2]), 64'(0));
            @(negedge clk);
            @(negedge clk);
            rn[2] = 1'b1;
            vcount = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk); #1;
                if (vld[2]) vcount++;
            end
            cmp("abort_no_valid", 64'(vcount), 64'(0));
            cmp("abort_rdata_reset", rdd[2], 64'h0);
        end
        access(2, 1'b1, 1'b0, 64'h18, 64'h0, 64'h55, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
